sse_feeder: RTL
===============

SSE_FEEDER -- requirements
Module: sse_feeder

Interface
REQ-001 Parameter DEPTH, default 16: per-stream FIFO depth in words (power of two, >=2).
REQ-002 Parameter W, default 32: sample width (IEEE-754 single).
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a run of cfg_len pairs.
REQ-006 cfg_len  input  16  number of sample pairs in the run; sampled on start.
REQ-007 ref_valid / ref_data  input  1 / W  reference-sample write port.
REQ-008 fir_valid / fir_data  input  1 / W  filter-output write port.
REQ-009 ref_full / fir_full  output  1 / 1  FIFO full flags.
REQ-010 next  input  1  one-cycle request from the SSE stage for the next pair.
REQ-011 A / B  output  W / W  current reference / filter sample presented to the SSE stage.
REQ-012 pause  output  1  high: no pair available yet; the SSE stage holds off.
REQ-013 stop  output  1  high: run exhausted; no further pairs.
REQ-014 busy  output  1  high from start until stop asserts.
REQ-015 issued  output  16  pairs delivered in the current run.
REQ-016 ovf / udf  output  1 / 1  sticky overflow / underflow error flags.

Function
REQ-017 Each stream SHALL be buffered in its own DEPTH-word synchronous FIFO; write when valid=1 and not full.
REQ-018 A write when full SHALL be dropped and SHALL set ovf.
REQ-019 start SHALL latch cfg_len, clear issued, stop, ovf, udf, set busy; FIFO contents SHALL be preserved.
REQ-020 pause SHALL equal busy AND (ref FIFO empty OR fir FIFO empty), combinationally from current FIFO state.
REQ-021 On a cycle with next=1, busy=1, issued<cfg_len and both FIFOs non-empty: pop both FIFOs at that edge, load A<=ref head, B<=fir head, issued<=issued+1.
REQ-022 A/B SHALL update at the edge next is sampled and hold until the next pop, so they are stable on the two following cycles.
REQ-023 On next=1 with issued==cfg_len: stop<=1 and busy<=0 at that edge; A/B hold; no pop.
REQ-024 On next=1 with busy=1, issued<cfg_len and either FIFO empty: no pop, A/B hold, udf<=1.
REQ-025 stop SHALL remain high until the next start or rst; next while stop=1 SHALL be ignored.
REQ-026 cfg_len=0: first next after start SHALL assert stop with no pop.
REQ-027 Simultaneous write and pop on one FIFO SHALL both take effect; count unchanged; a write to a full FIFO coincident with a pop SHALL be accepted.
REQ-028 start coincident with next: start SHALL take priority; next ignored.
REQ-029 next while busy=0 and stop=0 (before any start): ignored, no flags.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1.

Reset
REQ-031 rst SHALL clear both FIFOs (pointers, counts), A=0, B=0, issued=0, stop=0, busy=0, ovf=0, udf=0.
REQ-032 rst SHALL override start, next and writes in the same cycle.
REQ-033 rst mid-run SHALL abandon the run; the block is idle after rst until start.

Structure
REQ-034 Shared package SHALL hold default DEPTH, W and the 16-bit length width constant.
REQ-035 One sub-module sync_fifo (parameters DEPTH, W; push/pop/full/empty/count) SHALL be instantiated twice.
REQ-036 Control (issued counter, stop/busy, flags) SHALL live in sse_feeder; no FSM beyond the busy/stop bits.

Verification
REQ-037 cfg_len=3, write ref 1.0,2.0,3.0 and fir 1.5,2.0,2.0, three next pulses 6 cycles apart -> A/B = (3F800000,3FC00000),(40000000,40000000),(40400000,40000000); 4th next -> stop=1, busy=0, issued=3.
REQ-038 start cfg_len=2, only ref written -> pause=1; write fir word -> pause=0 next cycle.
REQ-039 Write 17 words to ref with DEPTH=16 -> ref_full=1 after 16th, 17th dropped, ovf=1, count 16.
REQ-040 next with fir FIFO empty, issued<cfg_len -> udf=1, A/B unchanged, issued unchanged.
REQ-041 Full FIFO, same-cycle write and next-pop -> count stays 16, new word appears after 15 later pops.
REQ-042 rst asserted after issued=2 of 5 -> all outputs at reset values next cycle, FIFOs empty, next ignored until start.

Source files
------------

// File: rtl/sse_feeder_pkg.sv
// rtl/sse_feeder_pkg.sv - shared constants and types for the SSE sample feeder
// Holds the default FIFO depth, the sample width and the run-length width.
package sse_feeder_pkg;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_W     = 32;
  localparam int LEN_W         = 16;

  typedef logic [LEN_W-1:0] len_t;
endpackage

// File: rtl/sse_feeder_if.sv
// rtl/sse_feeder_if.sv - bus bundle between the sample sources/SSE stage and the feeder
// master: drives start/cfg_len, both write ports and next; observes status and A/B.
// slave : the feeder itself.
interface sse_feeder_if
  import sse_feeder_pkg::*;
#(
  parameter int W = DEFAULT_W
);
  logic         start;
  len_t         cfg_len;
  logic         ref_valid;
  logic [W-1:0] ref_data;
  logic         fir_valid;
  logic [W-1:0] fir_data;
  logic         ref_full;
  logic         fir_full;
  logic         next;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         pause;
  logic         stop;
  logic         busy;
  len_t         issued;
  logic         ovf;
  logic         udf;

  modport master (
    output start, cfg_len, ref_valid, ref_data, fir_valid, fir_data, next,
    input  ref_full, fir_full, A, B, pause, stop, busy, issued, ovf, udf
  );

  modport slave (
    input  start, cfg_len, ref_valid, ref_data, fir_valid, fir_data, next,
    output ref_full, fir_full, A, B, pause, stop, busy, issued, ovf, udf
  );
endinterface

// File: rtl/sse_feeder_sync_fifo.sv
// rtl/sse_feeder_sync_fifo.sv - single-clock FIFO used for each sample stream
// Ports: clk, rst (sync, active-high); push_i/wdata_i write; pop_i pops the head
// shown on rdata_o; full_o, empty_o, count_o report occupancy.
module sync_fifo
  import sse_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = DEFAULT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sse_feeder.sv
// rtl/sse_feeder.sv - pairs reference and filter samples for the SSE stage
// Ports: clk, rst (sync, active-high); bus (sse_feeder_if.slave) carries run
// control, the two sample write ports, the next/A/B pair handshake and status.
module sse_feeder
  import sse_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = DEFAULT_W
) (
  input  logic          clk,
  input  logic          rst,
  sse_feeder_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  ref_rdata, fir_rdata;
  logic          ref_empty, fir_empty;
  logic [CW-1:0] ref_count, fir_count;
  logic          pop_go, ref_drop, fir_drop;

  logic [W-1:0] a_q, a_d, b_q, b_d;
  len_t         len_q, len_d, issued_q, issued_d;
  logic         busy_q, busy_d, stop_q, stop_d;
  logic         ovf_q, ovf_d, udf_q, udf_d;

  sync_fifo #(.DEPTH(DEPTH), .W(W)) u_ref_fifo (
    .clk(clk), .rst(rst),
    .push_i(bus.ref_valid), .wdata_i(bus.ref_data), .pop_i(pop_go),
    .rdata_o(ref_rdata), .full_o(bus.ref_full), .empty_o(ref_empty), .count_o(ref_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fir_fifo (
    .clk(clk), .rst(rst),
    .push_i(bus.fir_valid), .wdata_i(bus.fir_data), .pop_i(pop_go),
    .rdata_o(fir_rdata), .full_o(bus.fir_full), .empty_o(fir_empty), .count_o(fir_count)
  );

  // start wins over a coincident next, so next is masked on a start cycle.
  assign pop_go = bus.next && !bus.start && busy_q && (issued_q != len_q)
                  && !ref_empty && !fir_empty;

  // A write is lost only when the FIFO is full and no pop frees the head slot.
  assign ref_drop = bus.ref_valid && (ref_count == CW'(DEPTH)) && !pop_go;
  assign fir_drop = bus.fir_valid && (fir_count == CW'(DEPTH)) && !pop_go;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    len_d    = len_q;
    issued_d = issued_q;
    busy_d   = busy_q;
    stop_d   = stop_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.start) begin
      len_d    = bus.cfg_len;
      issued_d = '0;
      busy_d   = 1'b1;
      stop_d   = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else if (bus.next && busy_q) begin
      if (issued_q == len_q) begin
        stop_d = 1'b1;
        busy_d = 1'b0;
      end else if (pop_go) begin
        a_d      = ref_rdata;
        b_d      = fir_rdata;
        issued_d = issued_q + len_t'(1);
      end else begin
        udf_d = 1'b1;
      end
    end
    ovf_d = ovf_d | ref_drop | fir_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      len_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      busy_q   <= busy_d;
      stop_q   <= stop_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.busy   = busy_q;
  assign bus.stop   = stop_q;
  assign bus.issued = issued_q;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
  assign bus.pause  = busy_q && (ref_empty || fir_empty);
endmodule
